prio_event_encoder: RTL and testbench

- Registered, parametrised successor to the team's 4-input combinational priority encoder.
- Captures rising-edge events on N request lines into a pending register and applies a per-line mask.
- Presents the winning line as a 1-based code (0 = none) through a valid/ack handshake.
- Supports fixed-priority or round-robin selection. Sits between peripheral event lines and the control sequencer.

---
 rtl/prio_event_encoder.sv | 121 ++++++++++++
 tb/tb_prio_event_encoder.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prio_event_encoder.sv
// Edge-capturing priority encoder: latches rising edges on N request lines and
// presents the winning eligible line as a 1-based code through a valid/ack handshake.
module prio_event_encoder #(
    parameter int unsigned N  = 8,
    parameter int unsigned CW = $clog2(N + 1),
    parameter int unsigned RR = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  mask,
    input  logic          ack,
    output logic          valid,
    output logic [CW-1:0] code,
    output logic [N-1:0]  pending,
    output logic          overrun
);

    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } state_t;

    state_t        r_state;
    logic [N-1:0]  r_req_q;
    logic [N-1:0]  r_pending;
    logic          r_valid;
    logic [CW-1:0] r_code;
    logic          r_overrun;
    logic [IW-1:0] r_ptr;
    logic [IW-1:0] r_sel;

    logic [N-1:0]  w_edge;
    logic [N-1:0]  w_clr;
    logic [N-1:0]  w_eligible;
    logic [N-1:0]  w_low;
    logic [N-1:0]  w_cand;
    logic [IW-1:0] w_win;
    logic          w_any;
    logic          w_take;

    assign w_edge     = req & ~r_req_q;
    assign w_eligible = r_pending & mask;
    assign w_any      = |w_eligible;
    assign w_take     = (r_state == ST_PRESENT) & ack;

    // One-hot clear of the presented line on an accepted handshake.
    always_comb begin
        w_clr = '0;
        for (int i = 0; i < N; i++) begin
            if (w_take && (r_sel == IW'(i))) begin
                w_clr[i] = 1'b1;
            end
        end
    end

    // Rotating order (ptr down to 0, then wrap) is the highest index at or below
    // ptr if one exists, otherwise the highest index overall.
    always_comb begin
        w_low = '0;
        for (int i = 0; i < N; i++) begin
            w_low[i] = w_eligible[i] & (IW'(i) <= r_ptr);
        end
        w_cand = ((RR != 0) && (|w_low)) ? w_low : w_eligible;
        w_win  = '0;
        for (int i = 0; i < N; i++) begin
            if (w_cand[i]) begin
                w_win = IW'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_req_q   <= '0;
            r_pending <= '0;
            r_valid   <= 1'b0;
            r_code    <= '0;
            r_overrun <= 1'b0;
            r_ptr     <= IW'(N - 1);
            r_sel     <= '0;
        end else begin
            r_req_q   <= req;
            r_pending <= w_edge | (r_pending & ~w_clr);
            r_overrun <= |(w_edge & r_pending & ~w_clr);
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_sel   <= w_win;
                        r_code  <= CW'(w_win) + CW'(1);
                        r_valid <= 1'b1;
                        r_state <= ST_PRESENT;
                    end else begin
                        r_code  <= '0;
                        r_valid <= 1'b0;
                    end
                end
                ST_PRESENT: begin
                    if (ack) begin
                        r_valid <= 1'b0;
                        r_code  <= '0;
                        r_state <= ST_IDLE;
                        if (RR != 0) begin
                            r_ptr <= (r_sel == '0) ? IW'(N - 1) : r_sel - IW'(1);
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign valid   = r_valid;
    assign code    = r_code;
    assign pending = r_pending;
    assign overrun = r_overrun;

endmodule

// File: tb/tb_prio_event_encoder.sv
// Bench for prio_event_encoder: fixed-priority and rotating instances share one
// stimulus stream and are compared every cycle against an event-level model.
module tb_prio_event_encoder;

    localparam int N  = 4;
    localparam int CW = 3;

    logic          clk;
    logic          rst_n;
    logic [N-1:0]  req;
    logic [N-1:0]  mask;
    logic          ack;

    logic          fix_valid, rr_valid;
    logic [CW-1:0] fix_code, rr_code;
    logic [N-1:0]  fix_pend, rr_pend;
    logic          fix_ovr, rr_ovr;

    int n_checks = 0;
    int n_errors = 0;

    prio_event_encoder #(.N(N), .CW(CW), .RR(0)) u_fix (
        .clk(clk), .rst_n(rst_n), .req(req), .mask(mask), .ack(ack),
        .valid(fix_valid), .code(fix_code), .pending(fix_pend), .overrun(fix_ovr)
    );

    prio_event_encoder #(.N(N), .CW(CW), .RR(1)) u_rr (
        .clk(clk), .rst_n(rst_n), .req(req), .mask(mask), .ack(ack),
        .valid(rr_valid), .code(rr_code), .pending(rr_pend), .overrun(rr_ovr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit [N-1:0] m_reqq [2];
    bit [N-1:0] m_pend [2];
    bit         m_valid[2];
    bit         m_ovr  [2];
    int         m_code [2];
    int         m_ptr  [2];

    function automatic int pick(input int rr, input int ptr, input bit [N-1:0] elig);
        if (rr == 0) begin
            for (int i = N - 1; i >= 0; i--)
                if (elig[i]) return i;
        end else begin
            for (int k = 0; k < N; k++) begin
                int j = (ptr - k + N) % N;
                if (elig[j]) return j;
            end
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int g = 0; g < 2; g++) begin
            m_reqq[g] = '0; m_pend[g] = '0; m_valid[g] = 1'b0;
            m_ovr[g] = 1'b0; m_code[g] = 0; m_ptr[g] = N - 1;
        end
    endtask

    task automatic model_step(input bit [N-1:0] r, input bit [N-1:0] mk, input bit a);
        for (int g = 0; g < 2; g++) begin
            bit [N-1:0] e, c;
            int w;
            e = r & ~m_reqq[g];
            c = '0;
            if (m_valid[g] && a) c = N'(1) << (m_code[g] - 1);
            m_ovr[g] = |(e & m_pend[g] & ~c);
            if (!m_valid[g]) begin
                w = pick(g, m_ptr[g], m_pend[g] & mk);
                if (w >= 0) begin
                    m_valid[g] = 1'b1;
                    m_code[g]  = w + 1;
                end
            end else if (a) begin
                if (g == 1) m_ptr[g] = (m_code[g] == 1) ? N - 1 : m_code[g] - 2;
                m_valid[g] = 1'b0;
                m_code[g]  = 0;
            end
            m_pend[g] = e | (m_pend[g] & ~c);
            m_reqq[g] = r;
        end
    endtask

    // Per-cycle comparison of both instances against the model.
    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (!rst_n) model_reset();
            else        model_step(req, mask, ack);
            #1;
            if (!rst_n) model_reset();
            chk("fix_valid", int'(fix_valid), int'(m_valid[0]));
            chk("fix_code",  int'(fix_code),  m_code[0]);
            chk("fix_pend",  int'(fix_pend),  int'(m_pend[0]));
            chk("fix_ovr",   int'(fix_ovr),   int'(m_ovr[0]));
            chk("rr_valid",  int'(rr_valid),  int'(m_valid[1]));
            chk("rr_code",   int'(rr_code),   m_code[1]);
            chk("rr_pend",   int'(rr_pend),   int'(m_pend[1]));
            chk("rr_ovr",    int'(rr_ovr),    int'(m_ovr[1]));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req = '0; ack = 1'b0; mask = '1;
        step(); step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic wait_grant(input string nm, input bit use_rr, input int exp_code);
        bit v;
        v = use_rr ? rr_valid : fix_valid;
        for (int t = 0; t < 20 && !v; t++) begin
            step();
            v = use_rr ? rr_valid : fix_valid;
        end
        chk({nm, "_grant_seen"}, int'(v), 1);
        chk({nm, "_code"}, use_rr ? int'(rr_code) : int'(fix_code), exp_code);
        ack = 1'b1;
        step();
        ack = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; req = '0; mask = '1; ack = 1'b0;
        do_reset();
        chk("reset_valid", int'(fix_valid), 0);
        chk("reset_pend",  int'(fix_pend), 0);

        // Single event: pending after first edge, grant after second.
        req = 4'b0100; step();
        chk("t1_pend", int'(fix_pend), 4);
        chk("t1_valid_early", int'(fix_valid), 0);
        step();
        chk("t1_valid", int'(fix_valid), 1);
        chk("t1_code", int'(fix_code), 3);
        ack = 1'b1; step(); ack = 1'b0;
        chk("t1_valid_after_ack", int'(fix_valid), 0);
        chk("t1_pend_after_ack", int'(fix_pend), 0);
        step(); step();
        chk("t1_level_no_regrant", int'(fix_valid), 0);
        req = '0; step();

        // Three simultaneous events, one-cycle bubble between grants.
        do_reset();
        req = 4'b1011; step(); req = '0; step();
        chk("t2_code_a", int'(fix_code), 4);
        ack = 1'b1; step(); ack = 1'b0;
        chk("t2_bubble_a", int'(fix_valid), 0);
        step();
        chk("t2_code_b", int'(fix_code), 2);
        ack = 1'b1; step(); ack = 1'b0;
        chk("t2_bubble_b", int'(fix_valid), 0);
        step();
        chk("t2_code_c", int'(fix_code), 1);
        ack = 1'b1; step(); ack = 1'b0;

        // Rotating priority with all lines repeatedly pulsed.
        do_reset();
        for (int it = 0; it < 5; it++) begin
            int exp_rr;
            exp_rr = (it == 4) ? 4 : 4 - it;
            req = 4'b1111; step(); req = '0;
            wait_grant("t3_rr", 1'b1, exp_rr);
            step();
        end

        // Masked line stays pending until unmasked.
        do_reset();
        mask = 4'b0001;
        req = 4'b1001; step(); req = '0;
        wait_grant("t4_masked", 1'b0, 1);
        chk("t4_pend_bit3", int'(fix_pend), 8);
        mask = 4'b1111;
        wait_grant("t4_unmasked", 1'b0, 4);

        // Overrun on re-pulse; no overrun when the pulse meets its own ack.
        do_reset();
        req = 4'b0100; step(); req = '0; step();
        chk("t5_presenting", int'(fix_code), 3);
        req = 4'b0100; step();
        chk("t5_overrun", int'(fix_ovr), 1);
        req = '0; step();
        chk("t5_overrun_pulse", int'(fix_ovr), 0);
        ack = 1'b1; req = 4'b0100; step();
        ack = 1'b0; req = '0;
        chk("t5_ack_edge_ovr", int'(fix_ovr), 0);
        chk("t5_ack_edge_pend", int'(fix_pend), 4);
        chk("t5_ack_edge_valid", int'(fix_valid), 0);
        step();

        // Asynchronous reset mid-handshake.
        do_reset();
        req = 4'b0100; step(); req = '0; step();
        chk("t6_pre_code", int'(fix_code), 3);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_async_valid", int'(fix_valid), 0);
        chk("t6_async_code",  int'(fix_code), 0);
        chk("t6_async_pend",  int'(fix_pend), 0);
        chk("t6_async_ovr",   int'(fix_ovr), 0);
        step(); rst_n = 1'b1;
        for (int t = 0; t < 3; t++) begin
            step();
            chk("t6_no_grant", int'(fix_valid), 0);
        end

        // Random traffic with occasional mask changes and mid-cycle resets.
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            req = req ^ (N'($urandom_range(0, 15)) & N'($urandom_range(0, 15)));
            if ($urandom_range(0, 19) == 0) mask = N'($urandom_range(0, 15));
            else if ($urandom_range(0, 39) == 0) mask = '1;
            ack = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 299) == 0) rst_n = 1'b0;
            else rst_n = 1'b1;
            step();
        end
        rst_n = 1'b1; ack = 1'b0; req = '0;
        step(); step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
